// File: rtl/scd_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code decoder.
// Holds the decode/intake state enums, the queued event layout, modifier
// state, the prefix/response/key code constants and small decode helpers.
package scd_pkg;

  localparam int unsigned CODE_W  = 8;
  localparam int unsigned EV_W    = 16;
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned PCNT_W  = 3;

  // Prefix bytes
  localparam logic [CODE_W-1:0] PFX_E0 = 8'hE0;
  localparam logic [CODE_W-1:0] PFX_F0 = 8'hF0;
  localparam logic [CODE_W-1:0] PFX_E1 = 8'hE1;

  // Device response bytes
  localparam logic [CODE_W-1:0] RSP_BAT_OK = 8'hAA;
  localparam logic [CODE_W-1:0] RSP_ACK    = 8'hFA;
  localparam logic [CODE_W-1:0] RSP_ECHO   = 8'hEE;
  localparam logic [CODE_W-1:0] RSP_RESEND = 8'hFE;
  localparam logic [CODE_W-1:0] RSP_BAT_ER = 8'hFC;
  localparam logic [CODE_W-1:0] RSP_ERR0   = 8'h00;
  localparam logic [CODE_W-1:0] RSP_ERR1   = 8'hFF;

  // Modifier / special key codes
  localparam logic [CODE_W-1:0] KEY_LSHIFT = 8'h12;
  localparam logic [CODE_W-1:0] KEY_RSHIFT = 8'h59;
  localparam logic [CODE_W-1:0] KEY_CTRL   = 8'h14;
  localparam logic [CODE_W-1:0] KEY_ALT    = 8'h11;
  localparam logic [CODE_W-1:0] KEY_CAPS   = 8'h58;
  localparam logic [CODE_W-1:0] KEY_FAKE2  = 8'h7C;
  localparam logic [CODE_W-1:0] KEY_PAUSE  = 8'h77;

  // Bytes following E1 that belong to the pause sequence
  localparam logic [PCNT_W-1:0] PAUSE_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_PAUSE
  } dec_state_e;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_ACK,
    IN_WAIT
  } in_state_e;

  typedef struct packed {
    logic              brk;
    logic              ext;
    logic              caps;
    logic              alt;
    logic              ctrl;
    logic              shift;
    logic [1:0]        rsvd;
    logic [CODE_W-1:0] code;
  } scd_event_t;

  typedef struct packed {
    logic lshift;
    logic rshift;
    logic lctrl;
    logic rctrl;
    logic lalt;
    logic ralt;
    logic caps;
    logic caps_held;
  } mod_state_t;

  function automatic logic is_response(input logic [CODE_W-1:0] b);
    return (b == RSP_BAT_OK) || (b == RSP_ACK) || (b == RSP_ECHO) ||
           (b == RSP_RESEND) || (b == RSP_BAT_ER) || (b == RSP_ERR0) ||
           (b == RSP_ERR1);
  endfunction

  // E0 12 / E0 7C wrappers emitted around some extended keys
  function automatic logic is_fake_shift(input logic [CODE_W-1:0] b);
    return (b == KEY_LSHIFT) || (b == KEY_FAKE2);
  endfunction

  // Apply one make/break to the modifier state
  function automatic mod_state_t mod_update(input mod_state_t m, input logic brk,
                                            input logic ext, input logic [CODE_W-1:0] code);
    mod_state_t r;
    r = m;
    case (code)
      KEY_LSHIFT: if (!ext) r.lshift = ~brk;
      KEY_RSHIFT: if (!ext) r.rshift = ~brk;
      KEY_CTRL: begin
        if (ext) r.rctrl = ~brk;
        else     r.lctrl = ~brk;
      end
      KEY_ALT: begin
        if (ext) r.ralt = ~brk;
        else     r.lalt = ~brk;
      end
      KEY_CAPS: begin
        if (!ext) begin
          if (brk) begin
            r.caps_held = 1'b0;
          end else begin
            // Typematic repeats of a held caps key must not toggle again
            if (!m.caps_held) r.caps = ~m.caps;
            r.caps_held = 1'b1;
          end
        end
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_fifo.sv
// scd_fifo: synchronous event FIFO, pDepth x 16, async active-high reset.
// Ports: clk_i, rst_i, push_i/dat_i (write), pop_i (read, ignored when empty),
// dat_o (head, zero latency), full_o, empty_o, cnt_o (entries queued).
// Push on a full FIFO is accepted only when a pop happens in the same cycle.
module scd_fifo
  import scd_pkg::*;
#(
  parameter int unsigned pDepth = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [EV_W-1:0]   dat_i,
  input  logic              pop_i,
  output logic [EV_W-1:0]   dat_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  cnt_o
);

  localparam int unsigned AW = $clog2(pDepth);

  logic [EV_W-1:0]  mem_q [pDepth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en_c, rd_en_c;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(pDepth));
  assign cnt_o   = cnt_q;
  assign dat_o   = mem_q[rd_ptr_q];

  // Enables and pointer/count update; pointers wrap naturally (pDepth is 2^AW)
  always_comb begin
    rd_en_c  = pop_i & ~empty_o;
    wr_en_c  = push_i & (~full_o | rd_en_c);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en_c) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en_c, rd_en_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array, no reset needed: contents only visible when not empty
  always_ff @(posedge clk_i) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= dat_i;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns PS/2 set-2 scan-code bytes into 16-bit key events.
// Intake: rx_rdy_i/rx_dat_i/rx_perr_i in, rx_ack_o pulse (pAckLen clks) out.
// Events: ev_rd_i pop, ev_dat_o head {brk,ext,caps,alt,ctrl,shift,2'b0,code},
//   ev_empty_o, ev_cnt_o, irq_o, ovf_o (sticky, ovf_clr_i clears).
// Status: perr_cnt_o (saturating), resp_o/resp_vld_o (last device response).
// Optional: define SCD_TYPEMATIC_FILTER_EN to drop typematic repeat makes.
module ps2_scancode_decoder
  import scd_pkg::*;
#(
  parameter int unsigned pDepth  = 16,
  parameter int unsigned pAckLen = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        rx_rdy_i,
  input  logic [7:0]  rx_dat_i,
  input  logic        rx_perr_i,
  output logic        rx_ack_o,
  input  logic        ev_rd_i,
  output logic [15:0] ev_dat_o,
  output logic        ev_empty_o,
  output logic [6:0]  ev_cnt_o,
  output logic        irq_o,
  output logic        ovf_o,
  input  logic        ovf_clr_i,
  output logic [7:0]  perr_cnt_o,
  output logic [7:0]  resp_o,
  output logic        resp_vld_o
);

  localparam int unsigned ACK_W = $clog2(pAckLen) + 1;

  // Intake handshake
  in_state_e         in_state_q, in_state_d;
  logic [ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic              ack_q;
  logic              latch_c;
  logic [CODE_W-1:0] byte_q;
  logic              perr_q;
  logic              byte_vld_q;

  // Decoder
  dec_state_e        dec_state_q, dec_state_d;
  logic [PCNT_W-1:0] pause_cnt_q, pause_cnt_d;
  mod_state_t        mods_q, mods_d;
  logic [7:0]        perr_cnt_q, perr_cnt_d;
  logic [7:0]        resp_q, resp_d;
  logic              resp_vld_q, resp_vld_d;
  logic              resp_set_c;
  logic              key_vld_c, key_brk_c, key_ext_c;
  logic [CODE_W-1:0] key_code_c;
  logic              drop_rpt_c;
  logic              push_c;
  scd_event_t        ev_c;

`ifdef SCD_TYPEMATIC_FILTER_EN
  logic              last_vld_q, last_vld_d;
  logic [CODE_W:0]   last_key_q, last_key_d;
`endif

  // Status
  logic              ovf_q, ovf_d;
  logic              fifo_full, fifo_empty;
  logic              pop_c, drop_c;

  // Intake FSM: latch, ack for pAckLen clocks, then wait for rx_rdy_i low
  always_comb begin
    in_state_d = in_state_q;
    ack_cnt_d  = ack_cnt_q;
    latch_c    = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        if (rx_rdy_i) begin
          latch_c    = 1'b1;
          ack_cnt_d  = ACK_W'(pAckLen);
          in_state_d = IN_ACK;
        end
      end
      IN_ACK: begin
        ack_cnt_d = ack_cnt_q - ACK_W'(1);
        if (ack_cnt_q == ACK_W'(1)) in_state_d = IN_WAIT;
      end
      IN_WAIT: begin
        if (!rx_rdy_i) in_state_d = IN_IDLE;
      end
      default: in_state_d = IN_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_state_q <= IN_IDLE;
      ack_cnt_q  <= '0;
      ack_q      <= 1'b0;
      byte_q     <= '0;
      perr_q     <= 1'b0;
      byte_vld_q <= 1'b0;
    end else begin
      in_state_q <= in_state_d;
      ack_cnt_q  <= ack_cnt_d;
      ack_q      <= (in_state_d == IN_ACK);
      byte_vld_q <= latch_c;
      if (latch_c) begin
        byte_q <= rx_dat_i;
        perr_q <= rx_perr_i;
      end
    end
  end

  // Decode FSM, modifier tracking and event emission
  always_comb begin
    dec_state_d = dec_state_q;
    pause_cnt_d = pause_cnt_q;
    mods_d      = mods_q;
    perr_cnt_d  = perr_cnt_q;
    resp_d      = resp_q;
    resp_set_c  = 1'b0;
    key_vld_c   = 1'b0;
    key_brk_c   = 1'b0;
    key_ext_c   = 1'b0;
    key_code_c  = byte_q;
    drop_rpt_c  = 1'b0;
    push_c      = 1'b0;
`ifdef SCD_TYPEMATIC_FILTER_EN
    last_vld_d  = last_vld_q;
    last_key_d  = last_key_q;
`endif

    if (byte_vld_q) begin
      if (perr_q) begin
        if (perr_cnt_q != 8'hFF) perr_cnt_d = perr_cnt_q + 8'd1;
        dec_state_d = ST_IDLE;
        pause_cnt_d = '0;
      end else begin
        case (dec_state_q)
          ST_IDLE: begin
            if (byte_q == PFX_E0) begin
              dec_state_d = ST_E0;
            end else if (byte_q == PFX_F0) begin
              dec_state_d = ST_F0;
            end else if (byte_q == PFX_E1) begin
              dec_state_d = ST_PAUSE;
              pause_cnt_d = PAUSE_LEN;
            end else if (is_response(byte_q)) begin
              resp_d     = byte_q;
              resp_set_c = 1'b1;
            end else begin
              key_vld_c = 1'b1;
            end
          end
          ST_E0, ST_F0, ST_E0F0: begin
            // A stray prefix restarts the sequence from that prefix
            if (byte_q == PFX_E0) begin
              dec_state_d = ST_E0;
            end else if (byte_q == PFX_E1) begin
              dec_state_d = ST_PAUSE;
              pause_cnt_d = PAUSE_LEN;
            end else if (byte_q == PFX_F0) begin
              dec_state_d = (dec_state_q == ST_E0) ? ST_E0F0 : ST_F0;
            end else begin
              dec_state_d = ST_IDLE;
              if (dec_state_q == ST_F0) begin
                key_vld_c = 1'b1;
                key_brk_c = 1'b1;
              end else if (!is_fake_shift(byte_q)) begin
                key_vld_c = 1'b1;
                key_ext_c = 1'b1;
                key_brk_c = (dec_state_q == ST_E0F0);
              end
            end
          end
          ST_PAUSE: begin
            if (pause_cnt_q == PCNT_W'(1)) begin
              key_vld_c   = 1'b1;
              key_ext_c   = 1'b1;
              key_code_c  = KEY_PAUSE;
              pause_cnt_d = '0;
              dec_state_d = ST_IDLE;
            end else begin
              pause_cnt_d = pause_cnt_q - PCNT_W'(1);
            end
          end
          default: dec_state_d = ST_IDLE;
        endcase
      end
    end

    if (key_vld_c) begin
`ifdef SCD_TYPEMATIC_FILTER_EN
      if (key_brk_c) begin
        last_vld_d = 1'b0;
      end else if (last_vld_q && (last_key_q == {key_ext_c, key_code_c})) begin
        drop_rpt_c = 1'b1;
      end else begin
        last_vld_d = 1'b1;
        last_key_d = {key_ext_c, key_code_c};
      end
`endif
      if (!drop_rpt_c) begin
        mods_d = mod_update(mods_q, key_brk_c, key_ext_c, key_code_c);
        push_c = 1'b1;
      end
    end

    // Event carries the modifier state after this key's own update
    ev_c.brk   = key_brk_c;
    ev_c.ext   = key_ext_c;
    ev_c.caps  = mods_d.caps;
    ev_c.alt   = mods_d.lalt | mods_d.ralt;
    ev_c.ctrl  = mods_d.lctrl | mods_d.rctrl;
    ev_c.shift = mods_d.lshift | mods_d.rshift;
    ev_c.rsvd  = 2'b00;
    ev_c.code  = key_code_c;
  end

  // Sticky status flags; a new set beats a same-cycle clear
  always_comb begin
    pop_c      = ev_rd_i & ~fifo_empty;
    drop_c     = push_c & fifo_full & ~pop_c;
    ovf_d      = ovf_q;
    resp_vld_d = resp_vld_q;
    if (ovf_clr_i) begin
      ovf_d      = 1'b0;
      resp_vld_d = 1'b0;
    end
    if (drop_c)     ovf_d      = 1'b1;
    if (resp_set_c) resp_vld_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dec_state_q <= ST_IDLE;
      pause_cnt_q <= '0;
      mods_q      <= '0;
      perr_cnt_q  <= '0;
      resp_q      <= '0;
      resp_vld_q  <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef SCD_TYPEMATIC_FILTER_EN
      last_vld_q  <= 1'b0;
      last_key_q  <= '0;
`endif
    end else begin
      dec_state_q <= dec_state_d;
      pause_cnt_q <= pause_cnt_d;
      mods_q      <= mods_d;
      perr_cnt_q  <= perr_cnt_d;
      resp_q      <= resp_d;
      resp_vld_q  <= resp_vld_d;
      ovf_q       <= ovf_d;
`ifdef SCD_TYPEMATIC_FILTER_EN
      last_vld_q  <= last_vld_d;
      last_key_q  <= last_key_d;
`endif
    end
  end

  scd_fifo #(.pDepth(pDepth)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_c),
    .dat_i   (ev_c),
    .pop_i   (ev_rd_i),
    .dat_o   (ev_dat_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (ev_cnt_o)
  );

  assign rx_ack_o   = ack_q;
  assign ev_empty_o = fifo_empty;
  assign irq_o      = ~fifo_empty;
  assign ovf_o      = ovf_q;
  assign perr_cnt_o = perr_cnt_q;
  assign resp_o     = resp_q;
  assign resp_vld_o = resp_vld_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder (pDepth=16, pAckLen=1).
module tb_ps2_scancode_decoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        rx_rdy_i;
  logic [7:0]  rx_dat_i;
  logic        rx_perr_i;
  logic        rx_ack_o;
  logic        ev_rd_i;
  logic [15:0] ev_dat_o;
  logic        ev_empty_o;
  logic [6:0]  ev_cnt_o;
  logic        irq_o;
  logic        ovf_o;
  logic        ovf_clr_i;
  logic [7:0]  perr_cnt_o;
  logic [7:0]  resp_o;
  logic        resp_vld_o;

  int checks = 0;
  int errors = 0;

  ps2_scancode_decoder #(.pDepth(16), .pAckLen(1)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rx_rdy_i   (rx_rdy_i),
    .rx_dat_i   (rx_dat_i),
    .rx_perr_i  (rx_perr_i),
    .rx_ack_o   (rx_ack_o),
    .ev_rd_i    (ev_rd_i),
    .ev_dat_o   (ev_dat_o),
    .ev_empty_o (ev_empty_o),
    .ev_cnt_o   (ev_cnt_o),
    .irq_o      (irq_o),
    .ovf_o      (ovf_o),
    .ovf_clr_i  (ovf_clr_i),
    .perr_cnt_o (perr_cnt_o),
    .resp_o     (resp_o),
    .resp_vld_o (resp_vld_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte as the receiver would; optionally pop in the push cycle
  task automatic send_byte(input logic [7:0] b, input logic pe, input logic pop_at_push);
    int   acks;
    logic seen;
    acks = 0;
    seen = 1'b0;
    @(negedge clk_i);
    rx_dat_i  = b;
    rx_perr_i = pe;
    rx_rdy_i  = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (rx_ack_o) begin
        seen     = 1'b1;
        acks++;
        rx_rdy_i = 1'b0;
        ev_rd_i  = pop_at_push;
      end
    end
    rx_rdy_i = 1'b0;
    chk("ack_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      ev_rd_i = 1'b0;
      if (rx_ack_o) acks++;
    end
    rx_perr_i = 1'b0;
    chk("ack_once", 32'(acks), 32'd1);
  endtask

  task automatic send_key(input logic [7:0] b);
    send_byte(b, 1'b0, 1'b0);
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] exp);
    @(negedge clk_i);
    chk("head_valid", 32'(ev_empty_o), 32'd0);
    chk(tag, 32'(ev_dat_o), 32'(exp));
    ev_rd_i = 1'b1;
    @(negedge clk_i);
    ev_rd_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i     = 1'b1;
    rx_rdy_i  = 1'b0;
    rx_dat_i  = 8'h00;
    rx_perr_i = 1'b0;
    ev_rd_i   = 1'b0;
    ovf_clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_empty", 32'(ev_empty_o), 32'd1);
    chk("rst_cnt",   32'(ev_cnt_o),   32'd0);
    chk("rst_irq",   32'(irq_o),      32'd0);
    chk("rst_ack",   32'(rx_ack_o),   32'd0);
    chk("rst_ovf",   32'(ovf_o),      32'd0);
    chk("rst_perr",  32'(perr_cnt_o), 32'd0);
    chk("rst_resp",  32'(resp_o),     32'd0);
    chk("rst_rvld",  32'(resp_vld_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Plain make and break
    send_key(8'h1C);
    chk("make_cnt", 32'(ev_cnt_o), 32'd1);
    chk("make_irq", 32'(irq_o), 32'd1);
    pop_expect("make_1c", 16'h001C);
    chk("make_drained", 32'(ev_empty_o), 32'd1);
    send_key(8'hF0); send_key(8'h1C);
    pop_expect("break_1c", 16'h801C);

    // Shift held around a key (shift is event bit 10)
    send_key(8'h12); send_key(8'h1C); send_key(8'hF0); send_key(8'h1C);
    send_key(8'hF0); send_key(8'h12);
    chk("shift_cnt", 32'(ev_cnt_o), 32'd4);
    pop_expect("shift_make",   16'h0412);
    pop_expect("shift_1c",     16'h041C);
    pop_expect("shift_1c_brk", 16'h841C);
    pop_expect("shift_brk",    16'h8012);

    // Extended keys and fake shift
    send_key(8'hE0); send_key(8'h75);
    send_key(8'hE0); send_key(8'hF0); send_key(8'h75);
    pop_expect("ext_make", 16'h4075);
    pop_expect("ext_brk",  16'hC075);
    send_key(8'hE0); send_key(8'h12); send_key(8'hE0); send_key(8'h75);
    chk("fake_cnt", 32'(ev_cnt_o), 32'd1);
    pop_expect("fake_ext", 16'h4075);

    // Pause sequence then a device response
    send_key(8'hE1); send_key(8'h14); send_key(8'h77); send_key(8'hE1);
    send_key(8'hF0); send_key(8'h14); send_key(8'hF0); send_key(8'h77);
    chk("pause_cnt", 32'(ev_cnt_o), 32'd1);
    pop_expect("pause_ev", 16'h4077);
    send_key(8'hAA);
    chk("resp_val",   32'(resp_o),     32'hAA);
    chk("resp_vld",   32'(resp_vld_o), 32'd1);
    chk("resp_noev",  32'(ev_empty_o), 32'd1);

    // Typematic repeats
    send_key(8'h1C); send_key(8'h1C); send_key(8'h1C);
`ifdef SCD_TYPEMATIC_FILTER_EN
    chk("rpt_cnt", 32'(ev_cnt_o), 32'd1);
    pop_expect("rpt_make", 16'h001C);
`else
    chk("rpt_cnt", 32'(ev_cnt_o), 32'd3);
    pop_expect("rpt_make0", 16'h001C);
    pop_expect("rpt_make1", 16'h001C);
    pop_expect("rpt_make2", 16'h001C);
`endif
    send_key(8'hF0); send_key(8'h1C);
    pop_expect("rpt_brk", 16'h801C);

    // Caps lock toggles on make only (caps is bit 13)
    send_key(8'h58); send_key(8'hF0); send_key(8'h58);
    send_key(8'h58); send_key(8'hF0); send_key(8'h58);
    pop_expect("caps_on",      16'h2058);
    pop_expect("caps_on_brk",  16'hA058);
    pop_expect("caps_off",     16'h0058);
    pop_expect("caps_off_brk", 16'h8058);

    // Right ctrl (ext 14, ctrl is bit 11)
    send_key(8'hE0); send_key(8'h14);
    send_key(8'hE0); send_key(8'hF0); send_key(8'h14);
    pop_expect("rctrl_make", 16'h4814);
    pop_expect("rctrl_brk",  16'hC014);

    // Parity error on E0 discards it and resets the decoder
    send_byte(8'hE0, 1'b1, 1'b0);
    chk("perr_cnt",  32'(perr_cnt_o), 32'd1);
    chk("perr_noev", 32'(ev_empty_o), 32'd1);
    send_key(8'h75);
    pop_expect("perr_next", 16'h0075);

    // Fill past capacity: 15..24 stored, 25 dropped
    for (int i = 0; i < 17; i++) send_key(8'(8'h15 + i));
    chk("ovf_cnt",  32'(ev_cnt_o), 32'd16);
    chk("ovf_flag", 32'(ovf_o),    32'd1);
    chk("ovf_head", 32'(ev_dat_o), 32'h0015);
    @(negedge clk_i);
    ovf_clr_i = 1'b1;
    @(negedge clk_i);
    ovf_clr_i = 1'b0;
    chk("ovf_clr",  32'(ovf_o),      32'd0);
    chk("rvld_clr", 32'(resp_vld_o), 32'd0);

    // Push and pop in the same cycle while full
    send_byte(8'h26, 1'b0, 1'b1);
    chk("full_pp_cnt", 32'(ev_cnt_o), 32'd16);
    chk("full_pp_ovf", 32'(ovf_o),    32'd0);
    for (int i = 0; i < 15; i++) pop_expect("drain", 16'(16'h0016 + i));
    pop_expect("drain_last", 16'h0026);
    chk("drain_empty", 32'(ev_empty_o), 32'd1);

    // Pop on empty is ignored
    @(negedge clk_i);
    ev_rd_i = 1'b1;
    @(negedge clk_i);
    ev_rd_i = 1'b0;
    chk("empty_pop_cnt",   32'(ev_cnt_o),   32'd0);
    chk("empty_pop_empty", 32'(ev_empty_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
